// File: rtl/rgb_pwm_led_controller.sv
// NUM_LEDS-channel RGB PWM driver. Config writes land in shadow registers and are committed together at a PWM wrap.
// Blink support (blink_cnt / blink_phase) is compiled in only when RGB_BLINK_EN is defined.
module rgb_pwm_led_controller #(
    parameter int NUM_LEDS  = 3,
    parameter int PWM_WIDTH = 8,
    parameter int BLINK_DIV = 4,
    localparam int LED_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [LED_W-1:0]     cfg_led,
    input  logic [1:0]           cfg_color,
    input  logic                 cfg_blink,
    input  logic [PWM_WIDTH-1:0] cfg_duty,
    output logic                 cfg_err,
    output logic [NUM_LEDS-1:0]  red_out,
    output logic [NUM_LEDS-1:0]  green_out,
    output logic [NUM_LEDS-1:0]  blue_out
);

    localparam logic [LED_W:0] LED_LIMIT = NUM_LEDS[LED_W:0];

    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic                 pending_q, pending_d;
    logic                 cfg_err_q, cfg_err_d;
    logic [1:0]           sh_color_q [NUM_LEDS];
    logic [1:0]           sh_color_d [NUM_LEDS];
    logic [PWM_WIDTH-1:0] sh_duty_q  [NUM_LEDS];
    logic [PWM_WIDTH-1:0] sh_duty_d  [NUM_LEDS];
    logic [1:0]           act_color_q[NUM_LEDS];
    logic [1:0]           act_color_d[NUM_LEDS];
    logic [PWM_WIDTH-1:0] act_duty_q [NUM_LEDS];
    logic [PWM_WIDTH-1:0] act_duty_d [NUM_LEDS];
    logic [NUM_LEDS-1:0]  red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic [NUM_LEDS-1:0]  led_en;
    logic [NUM_LEDS-1:0]  led_on;
    logic                 wrap, accept, idx_ok, commit;

    // Handshake: a write transfers on any rising edge where cfg_valid and cfg_ready are both high;
    // cfg_ready drops for the rest of the period once a valid-index write is pending commit.
    assign cfg_ready = ~pending_q;
    assign cfg_err   = cfg_err_q;
    assign red_out   = red_q;
    assign green_out = green_q;
    assign blue_out  = blue_q;

    assign wrap   = (pwm_cnt_q == {PWM_WIDTH{1'b1}});
    assign accept = cfg_valid & cfg_ready;
    assign idx_ok = ({1'b0, cfg_led} < LED_LIMIT);
    assign commit = wrap & pending_q;

`ifdef RGB_BLINK_EN
    localparam int BC_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BC_W-1:0] BLINK_LAST = BC_W'(BLINK_DIV - 1);

    logic [BC_W-1:0] blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic            sh_blink_q [NUM_LEDS];
    logic            sh_blink_d [NUM_LEDS];
    logic            act_blink_q[NUM_LEDS];
    logic            act_blink_d[NUM_LEDS];

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (wrap) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BC_W'(1);
            end
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            sh_blink_d[i]  = sh_blink_q[i];
            act_blink_d[i] = commit ? sh_blink_q[i] : act_blink_q[i];
            if (accept && idx_ok && (cfg_led == LED_W'(i))) begin
                sh_blink_d[i] = cfg_blink;
            end
            led_en[i] = ~act_blink_q[i] | blink_phase_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            for (int i = 0; i < NUM_LEDS; i++) begin
                sh_blink_q[i]  <= 1'b0;
                act_blink_q[i] <= 1'b0;
            end
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                sh_blink_q[i]  <= sh_blink_d[i];
                act_blink_q[i] <= act_blink_d[i];
            end
        end
    end
`else
    // Without blink support every LED is steady; cfg_blink and BLINK_DIV are intentionally unused.
    logic unused_blink;
    assign unused_blink = cfg_blink ^ (BLINK_DIV == 0);
    assign led_en       = {NUM_LEDS{1'b1}};
`endif

    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_WIDTH'(1);
        pending_d = pending_q;
        cfg_err_d = accept & ~idx_ok;
        if (commit) begin
            pending_d = 1'b0;
        end else if (accept && idx_ok) begin
            pending_d = 1'b1;
        end
        for (int i = 0; i < NUM_LEDS; i++) begin
            sh_color_d[i]  = sh_color_q[i];
            sh_duty_d[i]   = sh_duty_q[i];
            act_color_d[i] = commit ? sh_color_q[i] : act_color_q[i];
            act_duty_d[i]  = commit ? sh_duty_q[i]  : act_duty_q[i];
            if (accept && idx_ok && (cfg_led == LED_W'(i))) begin
                sh_color_d[i] = cfg_color;
                sh_duty_d[i]  = cfg_duty;
            end
        end
    end

    // Outputs are computed from the current counter and registered, so they trail pwm_cnt by one cycle.
    always_comb begin
        led_on  = '0;
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            led_on[i]  = (act_duty_q[i] > pwm_cnt_q) & led_en[i];
            red_d[i]   = led_on[i] & (act_color_q[i] == 2'b01);
            green_d[i] = led_on[i] & (act_color_q[i] == 2'b10);
            blue_d[i]  = led_on[i] & (act_color_q[i] == 2'b11);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= '0;
            pending_q <= 1'b0;
            cfg_err_q <= 1'b0;
            red_q     <= '0;
            green_q   <= '0;
            blue_q    <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                sh_color_q[i]  <= 2'b00;
                sh_duty_q[i]   <= '0;
                act_color_q[i] <= 2'b00;
                act_duty_q[i]  <= '0;
            end
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            pending_q <= pending_d;
            cfg_err_q <= cfg_err_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            for (int i = 0; i < NUM_LEDS; i++) begin
                sh_color_q[i]  <= sh_color_d[i];
                sh_duty_q[i]   <= sh_duty_d[i];
                act_color_q[i] <= act_color_d[i];
                act_duty_q[i]  <= act_duty_d[i];
            end
        end
    end

endmodule
